// File: rtl/fsqrt_wb.sv
// Writeback merge for fsqrt results: priority unit wins the register-file port, fsqrt results queue in a FIFO.
// Optional per-register pending tracking is enabled with `define FSQRT_WB_PEND_EN.
module fsqrt_wb #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sq_valid,
    input  logic [4:0]               sq_addr,
    input  logic [31:0]              sq_data,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_addr,
    input  logic [31:0]              alu_data,
    output logic                     wr_en,
    output logic [4:0]               wr_addr,
    output logic [31:0]              wr_data,
    output logic [31:0]              pend,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic          empty, full, pop, push, push_ok;

    assign head_addr = mem_addr[head];
    assign head_data = mem_data[head];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // Head drains whenever the port is free; a full buffer can still accept if it pops this cycle.
    assign pop       = !alu_valid && !empty;
    assign push      = sq_valid && (alu_valid || !empty);
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (pop)     head <= head + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push && !push_ok) ovf <= 1'b1;
            wr_en <= alu_valid || !empty || sq_valid;
            if (alu_valid) begin
                wr_addr <= alu_addr;
                wr_data <= alu_data;
            end else if (!empty) begin
                wr_addr <= head_addr;
                wr_data <= head_data;
            end else if (sq_valid) begin
                wr_addr <= sq_addr;
                wr_data <= sq_data;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[tail] <= sq_addr;
            mem_data[tail] <= sq_data;
        end
    end

`ifdef FSQRT_WB_PEND_EN
    // A counter per register so duplicate destinations keep pend set until the last one drains.
    for (genvar a = 0; a < 32; a++) begin : g_pend
        logic [CW-1:0] n;
        logic          inc, dec;
        assign inc = push_ok && (sq_addr == 5'(a));
        assign dec = pop && (head_addr == 5'(a));
        always_ff @(posedge clk or posedge rst) begin
            if (rst)              n <= '0;
            else if (inc && !dec) n <= n + CW'(1);
            else if (dec && !inc) n <= n - CW'(1);
        end
        assign pend[a] = |n;
    end
`else
    assign pend = '0;
`endif
endmodule

// File: tb/tb_fsqrt_wb.sv
// Scoreboard bench for fsqrt_wb: a queue model of the buffer predicts each writeback cycle.
module tb_fsqrt_wb;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sq_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]    sq_addr = '0, alu_addr = '0;
    logic [31:0]   sq_data = '0, alu_data = '0;
    logic          wr_en, ovf;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data, pend;
    logic [CW-1:0] count;

    fsqrt_wb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_data(sq_data),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend(pend), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic en; logic [4:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;

    wr_t         exp_q[$];
    ent_t        mq[$];
    logic        m_ovf = 1'b0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    int          checks = 0, errors = 0;
    string       phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p;
        p = '0;
`ifdef FSQRT_WB_PEND_EN
        foreach (mq[i]) p[mq[i].addr] = 1'b1;
`endif
        return p;
    endfunction

    task automatic check_state();
        chk("count", 32'(count), 32'(mq.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("pend", pend, m_pend());
    endtask

    task automatic check_out();
        wr_t w;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        w = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'(w.en));
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", wr_data, w.data);
        check_state();
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        wr_t  w;
        ent_t e, h;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        sq_valid  = sv; sq_addr  = sa; sq_data  = sd;
        e.addr = sa; e.data = sd;
        if (av) begin
            w = '{1'b1, aa, ad};
            if (sv) begin
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            w = '{1'b1, h.addr, h.data};
            if (sv) mq.push_back(e);
        end else if (sv) begin
            w = '{1'b1, sa, sd};
        end else begin
            w = '{1'b0, last_a, last_d};
        end
        last_a = w.addr;
        last_d = w.data;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        last_a = '0;
        last_d = '0;
    endtask

    initial begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("wr_en", 32'(wr_en), 32'd0);
        chk("wr_addr", 32'(wr_addr), 32'd0);
        chk("wr_data", wr_data, 32'd0);
        check_state();
        @(negedge clk);
        rst = 1'b0;

        phase = "bypass";
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h3F800000);
        idle(1);

        phase = "collision";
        step(1'b1, 5'd2, 32'h40000000, 1'b1, 5'd3, 32'h3FB504F3);
        idle(2);

        phase = "ordering";
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'd20, 32'hA000_0000 + 32'(i), 1'b1, 5'(i), 32'h1000_0000 + 32'(i));
        idle(5);

        phase = "full_push_pop";
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd21, 32'hB000_0000 + 32'(i), 1'b1, 5'(10 + i), 32'hC000_0000 + 32'(i));
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hC000_0004);
        idle(5);

        phase = "overflow";
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd22, 32'hD000_0000 + 32'(i), 1'b1, 5'(15 + i), 32'hE000_0000 + 32'(i));
        step(1'b1, 5'd23, 32'hDEAD_0000, 1'b1, 5'd9, 32'hBAD0_0009);
        idle(6);

        phase = "duplicates";
        step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd7, 32'h7777_0001);
        step(1'b1, 5'd1, 32'h1111_2222, 1'b1, 5'd7, 32'h7777_0002);
        idle(3);

        phase = "reset_mid_drain";
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd24, 32'hF000_0000 + 32'(i), 1'b1, 5'(25 + i), 32'h5000_0000 + 32'(i));
        @(negedge clk);
        alu_valid = 1'b0; sq_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        check_state();
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        phase = "random";
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom(),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom());
        idle(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsqrt_wb.md
FSQRT_WB -- requirements
Module: fsqrt_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of fsqrt-result buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sq_valid  input  1  fsqrt result valid (fsqrt flagout).
REQ-005 SHALL have port sq_addr  input  5  fsqrt destination register (fsqrt addout).
REQ-006 SHALL have port sq_data  input  32  fsqrt result, IEEE single.
REQ-007 SHALL have port alu_valid  input  1  priority FP-unit result valid.
REQ-008 SHALL have port alu_addr  input  5  priority-unit destination register.
REQ-009 SHALL have port alu_data  input  32  priority-unit result.
REQ-010 SHALL have port wr_en  output  1  register-file write enable, registered.
REQ-011 SHALL have port wr_addr  output  5  register-file write address, registered.
REQ-012 SHALL have port wr_data  output  32  register-file write data, registered.
REQ-013 SHALL have port pend  output  32  one bit per register with an fsqrt result still buffered.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  buffered entry count.
REQ-015 SHALL have port ovf  output  1  sticky overflow error flag.

Function
REQ-016 Both input streams are non-stallable; the block SHALL never apply backpressure.
REQ-017 Per cycle, the write source SHALL be chosen in priority order: alu_valid, then buffer head (count>0), then sq bypass (sq_valid with count==0), else idle.
REQ-018 The chosen source SHALL appear on wr_en/wr_addr/wr_data one cycle after sampling (latency 1); idle cycles SHALL drive wr_en=0, with wr_addr/wr_data holding their previous values.
REQ-019 An sq result that is not written this cycle (alu_valid=1 or count>0) SHALL be pushed at the buffer tail.
REQ-020 Buffer SHALL be FIFO; fsqrt results SHALL be written in arrival order; pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL be allowed at any count, including count==DEPTH (count unchanged).
REQ-022 A push at count==DEPTH without a same-cycle pop SHALL drop the incoming result, leave buffer contents unchanged, and set ovf=1.
REQ-023 ovf SHALL remain 1 until reset.
REQ-024 count SHALL equal entries held after the edge, range 0..DEPTH.
REQ-025 pend[a] SHALL be 1 iff at least one buffered entry has address a; duplicate addresses SHALL be tracked so pend[a] clears only after the last such entry pops.
REQ-026 The block SHALL NOT reorder alu writes against buffered sq writes to the same address; pend SHALL be used by issue logic to avoid that hazard.
REQ-027 Data SHALL pass unmodified (no rounding or flushing).

Reset
REQ-028 Asserting rst SHALL immediately clear wr_en, wr_addr, wr_data, pend, count, ovf and both pointers, discarding buffered entries, including mid-drain.
REQ-029 Inputs sampled on the first rising edge after rst deasserts SHALL be processed normally.

Configuration
REQ-030 With macro FSQRT_WB_PEND_EN defined, pend SHALL behave per REQ-025; without it, pend SHALL be constant 0 and the per-address tracking logic SHALL be absent.

Verification
REQ-031 Bypass: count=0, alu_valid=0, sq_valid=1, sq_addr=5, sq_data=0x3F800000 -> next cycle wr_en=1, wr_addr=5, wr_data=0x3F800000, count=0.
REQ-032 Collision: alu_valid=1 (addr 2, 0x40000000) with sq_valid=1 (addr 3, 0x3FB504F3) -> cycle+1 writes reg 2, count=1, pend[3]=1; cycle+2 writes reg 3, count=0, pend[3]=0.
REQ-033 Ordering: alu_valid held 1 for 4 cycles while sq delivers addrs 1,2,3,4 -> count=4; after alu drops, writes regs 1,2,3,4 on consecutive cycles, ovf=0.
REQ-034 Overflow: DEPTH=4, buffer full, alu_valid=1, sq_valid=1 addr 9 -> entry dropped, ovf=1, count=4, pend[9]=0; ovf stays 1 after drain.
REQ-035 Duplicates: two buffered entries to addr 7 -> pend[7] stays 1 after first pop, clears after second.
REQ-036 Reset mid-drain: count=3, assert rst -> wr_en=0, count=0, pend=0, ovf=0 immediately; no stale write after release.
